// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong match sequencer; optional pause state enabled by GAME_PAUSE_EN
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 90,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               refresh_tick,
    input  logic               start_btn,
    input  logic               score_player1,
    input  logic               score_player2,
`ifdef GAME_PAUSE_EN
    input  logic               pause_btn,
`endif
    output logic               ball_reset,
    output logic               ball_tick,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         winner,
    output logic [2:0]         state_o
);

    // Counter only ever holds 0..max-1, so clog2(max) bits are enough.
    localparam int MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
`ifdef GAME_PAUSE_EN
        , S_PAUSED = 3'd5
`endif
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SCORE_W-1:0] p1_n, p2_n, p1_inc, p2_inc;
    logic [1:0]         win_n;
    logic               start_q, s1_q, s2_q;
    logic               start_rise, s1_rise, s2_rise;
`ifdef GAME_PAUSE_EN
    logic               pause_q;
    logic               pause_rise;
    assign pause_rise = pause_btn & ~pause_q;
`endif

    assign start_rise = start_btn & ~start_q;
    assign s1_rise    = score_player1 & ~s1_q;
    assign s2_rise    = score_player2 & ~s2_q;

    // Saturating increments; WIN_SCORE normally stops play long before saturation.
    assign p1_inc = (p1_score == {SCORE_W{1'b1}}) ? p1_score : p1_score + SCORE_W'(1);
    assign p2_inc = (p2_score == {SCORE_W{1'b1}}) ? p2_score : p2_score + SCORE_W'(1);

    // The ball only runs in PLAY; PAUSED releases reset but withholds ticks so it freezes.
`ifdef GAME_PAUSE_EN
    assign ball_reset = (state != S_PLAY) && (state != S_PAUSED);
`else
    assign ball_reset = (state != S_PLAY);
`endif
    assign ball_tick  = refresh_tick && (state == S_PLAY);
    assign state_o    = state;

    // State, counters, scores and edge-detect history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            p1_score <= '0;
            p2_score <= '0;
            winner   <= 2'd0;
            start_q  <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
`ifdef GAME_PAUSE_EN
            pause_q  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            p1_score <= p1_n;
            p2_score <= p2_n;
            winner   <= win_n;
            start_q  <= start_btn;
            s1_q     <= score_player1;
            s2_q     <= score_player2;
`ifdef GAME_PAUSE_EN
            pause_q  <= pause_btn;
`endif
        end
    end

    // Next-state, tick counting and score/winner updates.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p1_n    = p1_score;
        p2_n    = p2_score;
        win_n   = winner;
        case (state)
            S_IDLE: begin
                if (start_rise) begin
                    state_n = S_SERVE;
                    cnt_n   = '0;
                end
            end
            S_SERVE: begin
                if (refresh_tick) begin
                    if (cnt == CNT_W'(SERVE_TICKS - 1)) begin
                        state_n = S_PLAY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (s1_rise && s2_rise) begin
                    // Both flags at once: rally is replayed without scoring.
                    state_n = S_POINT;
                    cnt_n   = '0;
                end else if (s1_rise) begin
                    p1_n  = p1_inc;
                    cnt_n = '0;
                    if (p1_inc == SCORE_W'(WIN_SCORE)) begin
                        state_n = S_OVER;
                        win_n   = 2'd1;
                    end else begin
                        state_n = S_POINT;
                    end
                end else if (s2_rise) begin
                    p2_n  = p2_inc;
                    cnt_n = '0;
                    if (p2_inc == SCORE_W'(WIN_SCORE)) begin
                        state_n = S_OVER;
                        win_n   = 2'd2;
                    end else begin
                        state_n = S_POINT;
                    end
                end
`ifdef GAME_PAUSE_EN
                else if (pause_rise) begin
                    state_n = S_PAUSED;
                    cnt_n   = '0;
                end
`endif
            end
            S_POINT: begin
                if (refresh_tick) begin
                    if (cnt == CNT_W'(POINT_TICKS - 1)) begin
                        state_n = S_SERVE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    state_n = S_SERVE;
                    cnt_n   = '0;
                    p1_n    = '0;
                    p2_n    = '0;
                    win_n   = 2'd0;
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSED: begin
                if (pause_rise) begin
                    state_n = S_PLAY;
                    cnt_n   = '0;
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule
